pipeline_hazard_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage RISC-V pipeline. It consumes the ID-stage decode fields (register indices plus class flags derived from opcode/func3) and keeps a private tag pipeline that mirrors EX, MEM and WB. From that state it drives the stall, flush, bubble and freeze controls and the EX operand-forwarding selects. It also sequences the pipeline through data-memory wait states and taken-branch redirects.

---
 rtl/pipeline_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and sequencing controller for the 5-stage RISC-V pipeline. It keeps
//   a private tag pipeline (EX, MEM, WB) fed from the ID decode fields. From
//   those tags it drives the stall/flush/bubble/freeze controls and the EX
//   forwarding selects.
//
//   Optional build macro: HAZ_PERF_CNT_EN enables the stall/flush performance
//   counters. When it is undefined, both counter ports are tied to zero.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   id_*              ID-stage decode fields (valid, rs1/rs2/rd, use flags,
//                     reg_write, is_load)
//   ex_branch_taken   EX resolved a taken branch/JAL/JALR
//   mem_ready         data memory completed its access this cycle
//   stall_if/stall_id hold PC / IF-ID register
//   flush_id          invalidate IF-ID register
//   bubble_ex         load NOP into ID-EX register
//   freeze            hold ID-EX, EX-MEM, MEM-WB registers
//   fwd_a_sel/b_sel   EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
//   perf_stall_cnt    load-use + memory-wait stall cycles
//   perf_flush_cnt    branch flush events
module pipeline_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_is_load,
  input  logic              ex_branch_taken,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_id,
  output logic              flush_id,
  output logic              bubble_ex,
  output logic              freeze,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [CNT_W-1:0]  perf_stall_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              is_load;
  } dst_t;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
  } src_t;

  // Valid bits of the tag slots as a shift register: [0]=EX, [1]=MEM, [2]=WB.
  logic [2:0] vld_pipe;
  dst_t       dst_ex, dst_mem, dst_wb;
  src_t       src_ex;

  logic ex_live, mem_live, wb_live;
  logic memwait, branch, loaduse_raw, loaduse, bubble;

  // x0 never produces a hazard or a forward.
  assign ex_live  = vld_pipe[0] && dst_ex.reg_write  && (dst_ex.rd  != '0);
  assign mem_live = vld_pipe[1] && dst_mem.reg_write && (dst_mem.rd != '0);
  assign wb_live  = vld_pipe[2] && dst_wb.reg_write  && (dst_wb.rd  != '0);

  assign loaduse_raw = id_valid && ex_live && dst_ex.is_load &&
                       ((id_use_rs1 && (id_rs1 == dst_ex.rd)) ||
                        (id_use_rs2 && (id_rs2 == dst_ex.rd)));

  // Priority: memory wait > taken branch > load-use. A taken branch already
  // squashes the ID instruction, so a load-use stall for it is moot.
  assign memwait = !mem_ready;
  assign branch  = !memwait && ex_branch_taken;
  assign loaduse = !memwait && !ex_branch_taken && loaduse_raw;
  assign bubble  = branch || loaduse;

  function automatic logic [1:0] fwd_pick(input logic use_src,
                                          input logic [REG_AW-1:0] src);
    fwd_pick = 2'b00;
    if (vld_pipe[0] && use_src) begin
      // The younger producer in MEM wins over WB.
      if (mem_live && (dst_mem.rd == src))     fwd_pick = 2'b01;
      else if (wb_live && (dst_wb.rd == src))  fwd_pick = 2'b10;
    end
  endfunction

  // Reset forces every control low in the same cycle.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    freeze    = 1'b0;
    fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00;
    if (!reset) begin
      stall_if  = memwait || loaduse;
      stall_id  = memwait || loaduse;
      flush_id  = branch;
      bubble_ex = bubble;
      freeze    = memwait;
      // Tags are held during a memory wait, so these stay stable.
      fwd_a_sel = fwd_pick(src_ex.use_rs1, src_ex.rs1);
      fwd_b_sel = fwd_pick(src_ex.use_rs2, src_ex.rs2);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      dst_ex   <= '0;
      dst_mem  <= '0;
      dst_wb   <= '0;
      src_ex   <= '0;
    end else if (!memwait) begin
      vld_pipe <= {vld_pipe[1:0], id_valid && !bubble};
      dst_wb   <= dst_mem;
      dst_mem  <= dst_ex;
      dst_ex   <= '{rd: id_rd, reg_write: id_reg_write, is_load: id_is_load};
      src_ex   <= '{rs1: id_rs1, rs2: id_rs2,
                    use_rs1: id_use_rs1, use_rs2: id_use_rs2};
    end
  end

  // is_load only matters in EX; the MEM/WB copies just travel with the tag.
  logic unused_tag;
  assign unused_tag = dst_mem.is_load ^ dst_wb.is_load;

`ifdef HAZ_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (memwait || loaduse) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (branch)             flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. It runs three phases:
//   1. A vector table of directed instruction sequences with hand-derived
//      control outputs.
//   2. Hand-written sequences for memory wait, branch-over-load-use and
//      reset during a stall, including the counters.
//   3. Random stimulus compared against an in-flight instruction model.
module tb_pipeline_hazard_ctrl;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 32;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load;
  logic ex_branch_taken, mem_ready;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic stall_if, stall_id, flush_id, bubble_ex, freeze;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id),
    .bubble_ex(bubble_ex), .freeze(freeze), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt));

  typedef struct packed {
    logic rst, v;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic u1, u2, rw, ld, br, mr;
  } in_t;

  typedef struct packed {
    logic sif, sid, fl, bub, frz;
    logic [1:0] fa, fb;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  out_t act;
  assign act = {stall_if, stall_id, flush_id, bubble_ex, freeze, fwd_a_sel, fwd_b_sel};

  int passed = 0;
  int total  = 0;

  function automatic in_t ins(int rd, int rs1, int rs2, bit u1, bit u2, bit rw, bit ld);
    in_t x;
    x = '0;
    x.v = 1'b1; x.rd = REG_AW'(rd); x.rs1 = REG_AW'(rs1); x.rs2 = REG_AW'(rs2);
    x.u1 = u1; x.u2 = u2; x.rw = rw; x.ld = ld; x.mr = 1'b1;
    return x;
  endfunction

  function automatic in_t nop();
    in_t x;
    x = '0;
    x.mr = 1'b1;
    return x;
  endfunction

  function automatic out_t o(bit sif, bit sid, bit fl, bit bub, bit frz, int fa, int fb);
    return {sif, sid, fl, bub, frz, 2'(fa), 2'(fb)};
  endfunction

  task automatic drive(input in_t x);
    reset = x.rst; id_valid = x.v; id_rs1 = x.rs1; id_rs2 = x.rs2; id_rd = x.rd;
    id_use_rs1 = x.u1; id_use_rs2 = x.u2; id_reg_write = x.rw; id_is_load = x.ld;
    ex_branch_taken = x.br; mem_ready = x.mr;
  endtask

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // One cycle: apply inputs, compare at the falling edge, move past the rising edge.
  task automatic step(input string nm, input in_t x, input out_t e);
    drive(x);
    @(negedge clk);
    check(nm, act, e);
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model: the in-flight instructions ----------------
  typedef struct packed {
    logic v;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic rw, ld, u1, u2;
  } ent_t;

  ent_t pipe [3];  // 0 = EX, 1 = MEM, 2 = WB
  logic [CNT_W-1:0] m_stall, m_flush;

  function automatic bit m_produces(int s);
    return pipe[s].v && pipe[s].rw && (pipe[s].rd != 0);
  endfunction

  function automatic bit m_needs_load(in_t x);
    if (!x.v || !m_produces(0) || !pipe[0].ld) return 1'b0;
    return (x.u1 && x.rs1 == pipe[0].rd) || (x.u2 && x.rs2 == pipe[0].rd);
  endfunction

  // Nearest older producer of the register wins; its distance is the select code.
  function automatic logic [1:0] m_fwd(bit use_src, logic [REG_AW-1:0] src);
    if (!pipe[0].v || !use_src) return 2'd0;
    for (int s = 1; s <= 2; s++)
      if (m_produces(s) && pipe[s].rd == src) return 2'(s);
    return 2'd0;
  endfunction

  function automatic out_t m_out(in_t x);
    out_t r;
    r = '0;
    if (x.rst) return r;
    if (!x.mr) begin
      r.sif = 1; r.sid = 1; r.frz = 1;
    end else if (x.br) begin
      r.fl = 1; r.bub = 1;
    end else if (m_needs_load(x)) begin
      r.sif = 1; r.sid = 1; r.bub = 1;
    end
    r.fa = m_fwd(pipe[0].u1, pipe[0].rs1);
    r.fb = m_fwd(pipe[0].u2, pipe[0].rs2);
    return r;
  endfunction

  task automatic m_step(input in_t x);
    bit squash;
    if (x.rst) begin
      for (int s = 0; s < 3; s++) pipe[s] = '0;
      m_stall = '0;
      m_flush = '0;
    end else if (!x.mr) begin
      m_stall = m_stall + 1;
    end else begin
      squash = x.br || m_needs_load(x);
      if (x.br) m_flush = m_flush + 1;
      else if (squash) m_stall = m_stall + 1;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = squash ? '0 : '{v: x.v, rd: x.rd, rs1: x.rs1, rs2: x.rs2,
                                rw: x.rw, ld: x.ld, u1: x.u1, u2: x.u2};
    end
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[$];
  in_t  rst_in, lw5, add6, addi3, sub4, lw0, add1, addi2, add8, x;
  out_t z, e;

  initial begin
    rst_in = nop(); rst_in.rst = 1'b1;
    lw5   = ins(5, 1, 0, 1, 0, 1, 1);
    add6  = ins(6, 5, 7, 1, 1, 1, 0);
    addi3 = ins(3, 0, 0, 1, 0, 1, 0);
    sub4  = ins(4, 3, 3, 1, 1, 1, 0);
    lw0   = ins(0, 1, 0, 1, 0, 1, 1);
    add1  = ins(1, 0, 0, 1, 1, 1, 0);
    addi2 = ins(2, 0, 0, 1, 0, 1, 0);
    add8  = ins(8, 2, 3, 1, 1, 1, 0);
    z     = o(0, 0, 0, 0, 0, 0, 0);

    // Load-use: one stall, then the ADD picks up the load from WB.
    tbl.push_back('{rst_in, z});
    tbl.push_back('{rst_in, z});
    tbl.push_back('{lw5,  z});
    tbl.push_back('{add6, o(1, 1, 0, 1, 0, 0, 0)});
    tbl.push_back('{add6, z});
    tbl.push_back('{nop(), o(0, 0, 0, 0, 0, 2, 0)});
    tbl.push_back('{nop(), z});
    tbl.push_back('{nop(), z});
    // Back-to-back ALU: SUB in EX takes both operands from MEM.
    tbl.push_back('{addi3, z});
    tbl.push_back('{sub4,  z});
    tbl.push_back('{nop(), o(0, 0, 0, 0, 0, 1, 1)});
    tbl.push_back('{nop(), z});
    tbl.push_back('{nop(), z});
    // x0 is neither a load-use hazard nor a forward source.
    tbl.push_back('{lw0,  z});
    tbl.push_back('{add1, z});
    tbl.push_back('{nop(), z});
    // Operand A from WB, operand B from MEM.
    tbl.push_back('{addi2, z});
    tbl.push_back('{addi3, z});
    tbl.push_back('{add8,  z});
    tbl.push_back('{nop(), o(0, 0, 0, 0, 0, 2, 1)});

    foreach (tbl[k]) step($sformatf("tbl[%0d]", k), tbl[k].i, tbl[k].e);

    // Memory wait while MEM holds ADDI x9 and EX holds its consumer.
    step("mw_rst", rst_in, z);
    step("mw_addi9", ins(9, 1, 0, 1, 0, 1, 0), z);
    step("mw_add10", ins(10, 9, 9, 1, 1, 1, 0), z);
    x = nop(); x.mr = 1'b0;
    for (int c = 0; c < 3; c++) step($sformatf("mw_wait%0d", c), x, o(1, 1, 0, 0, 1, 1, 1));
    drive(nop());
    @(negedge clk);
    check("mw_release", act, o(0, 0, 0, 0, 0, 1, 1));
    check("mw_stall_cnt", perf_stall_cnt, PERF ? 3 : 0);
    @(posedge clk);
    #1;
    check("mw_stall_cnt_hold", perf_stall_cnt, PERF ? 3 : 0);
    step("mw_resume", nop(), z);

    // Taken branch in the same cycle as a load-use hazard.
    step("br_rst", rst_in, z);
    check("br_flush_cnt0", perf_flush_cnt, 0);
    step("br_lw5", lw5, z);
    x = add6; x.br = 1'b1;
    step("br_over_lu", x, o(0, 0, 1, 1, 0, 0, 0));
    check("br_flush_cnt", perf_flush_cnt, PERF ? 1 : 0);
    check("br_stall_cnt", perf_stall_cnt, 0);
    step("br_after", nop(), z);

    // Reset during a load-use cycle wipes the load tag.
    step("rs_lw5", lw5, z);
    x = add6; x.rst = 1'b1;
    step("rs_during", x, z);
    step("rs_next", add6, z);
    step("rs_nofwd", nop(), z);
    check("rs_stall_cnt", perf_stall_cnt, 0);

    // Random traffic against the model; narrow register range to force hazards.
    drive(rst_in);
    m_step(rst_in);
    @(posedge clk);
    #1;
    for (int c = 0; c < 3000; c++) begin
      x.rst = ($urandom_range(0, 99) == 0);
      x.v   = ($urandom_range(0, 9) != 0);
      x.rs1 = REG_AW'($urandom_range(0, 3));
      x.rs2 = REG_AW'($urandom_range(0, 3));
      x.rd  = REG_AW'($urandom_range(0, 3));
      x.u1  = 1'($urandom);
      x.u2  = 1'($urandom);
      x.rw  = ($urandom_range(0, 4) != 0);
      x.ld  = ($urandom_range(0, 2) == 0);
      x.br  = ($urandom_range(0, 9) == 0);
      x.mr  = ($urandom_range(0, 7) != 0);
      drive(x);
      e = m_out(x);
      @(negedge clk);
      check($sformatf("rand_ctl[%0d]", c), act, e);
      check($sformatf("rand_stall_cnt[%0d]", c), perf_stall_cnt, PERF ? m_stall : 0);
      check($sformatf("rand_flush_cnt[%0d]", c), perf_flush_cnt, PERF ? m_flush : 0);
      @(posedge clk);
      m_step(x);
      #1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
